// File: rtl/led_pattern_engine_if.sv
// led_pattern_engine_if: control/status bundle for the LED pattern engine.
//   en    : run enable (master -> engine)
//   mode  : pattern select 0 BLINK, 1 MARQUEE, 2 PINGPONG, 3 COUNT
//   speed : rate select, tick period = 2^(DIV_W-speed) cycles
//   led   : registered pattern output (engine -> master)
//   tick  : one-cycle pulse in the cycle led shows a tick-driven update
interface led_pattern_engine_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic [WIDTH-1:0] led;
  logic             tick;

  modport master (output en, output mode, output speed, input led, input tick);
  modport slave  (input en, input mode, input speed, output led, output tick);
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: prescaled LED pattern generator (blink, marquee,
// ping-pong bounce, binary count).
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : led_pattern_engine_if slave (en, mode, speed in; led, tick out)
module led_pattern_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV_W = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  led_pattern_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_BLINK    = 2'd0,
    MODE_MARQUEE  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_COUNT    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [DIV_W-1:0] cnt_q, cnt_d, step_mask;
  logic [WIDTH-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_q, mode_in;
  logic             tick_q, tick_d;
  logic             step, mode_chg, led_onehot;

  function automatic logic [WIDTH-1:0] init_pattern(input mode_e m);
    logic [WIDTH-1:0] p;
    p = '0;
    if (m == MODE_MARQUEE || m == MODE_PINGPONG) p[0] = 1'b1;
    return p;
  endfunction

  always_comb begin
    mode_in   = mode_e'(bus.mode);
    mode_chg  = (mode_in != mode_q);
    // Low DIV_W-speed bits of the prescaler must all be ones to step.
    step_mask = '1;
    step_mask = step_mask >> bus.speed;
    step      = bus.en && ((cnt_q & step_mask) == step_mask);
    led_onehot = (led_q != '0) && ((led_q & (led_q - 1'b1)) == '0);

    cnt_d  = cnt_q;
    led_d  = led_q;
    dir_d  = dir_q;
    tick_d = 1'b0;

    if (mode_chg) begin
      // Mode change wins over a coincident step, independent of en.
      led_d = init_pattern(mode_in);
      cnt_d = '0;
      dir_d = DIR_LEFT;
    end else begin
      if (bus.en) cnt_d = cnt_q + 1'b1;
      if (step) begin
        tick_d = 1'b1;
        case (mode_q)
          MODE_BLINK:   led_d = led_q[0] ? '0 : '1;
          MODE_MARQUEE: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          MODE_PINGPONG: begin
            if (!led_onehot) begin
              led_d = init_pattern(MODE_PINGPONG);
              dir_d = DIR_LEFT;
            end else if (dir_q == DIR_LEFT && led_q[WIDTH-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else if (dir_q == DIR_RIGHT && led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else if (dir_q == DIR_LEFT) begin
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
          default:      led_d = led_q + 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      dir_q  <= DIR_LEFT;
      mode_q <= mode_in;
      led_q  <= init_pattern(mode_in);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      dir_q  <= dir_d;
      mode_q <= mode_in;
      led_q  <= led_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of LED outputs; legal range 2..32.
REQ-002 SHALL have parameter DIV_W, default 27, prescaler counter width; legal range 4..32, DIV_W > 3.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  run enable; 0 freezes prescaler and pattern.
REQ-006 SHALL have port mode  input  2  pattern select: 0 BLINK, 1 MARQUEE, 2 PINGPONG, 3 COUNT.
REQ-007 SHALL have port speed  input  2  rate select; tick period = 2^(DIV_W-speed) clk cycles.
REQ-008 SHALL have port led  output  WIDTH  registered pattern output.
REQ-009 SHALL have port tick  output  1  registered one-cycle pulse; high in exactly the cycle led shows a tick-driven update.

Function
REQ-010 SHALL keep a DIV_W-bit prescaler cnt that increments by 1 each cycle while en=1, wraps modulo 2^DIV_W, and holds while en=0.
REQ-011 SHALL raise internal step when en=1 and cnt bits [DIV_W-speed-1:0] are all ones; speed changes take effect immediately, cnt is not cleared.
REQ-012 SHALL register mode into mode_q each cycle; a mode change is mode != mode_q.
REQ-013 SHALL define init(m): BLINK all zeros; MARQUEE 1 (bit 0); PINGPONG 1 (bit 0); COUNT all zeros.
REQ-014 SHALL, on a mode change, load led <= init(mode), clear cnt to 0, set dir=LEFT, and keep tick low; this applies regardless of en.
REQ-015 SHALL give mode change priority over step in the same cycle; that step is discarded.
REQ-016 SHALL, on step with no mode change, update led in the next cycle per mode_q and drive tick=1 in that cycle.
REQ-017 BLINK: led <= (led[0]==1) ? all zeros : all ones.
REQ-018 MARQUEE: led <= {led[WIDTH-2:0], led[WIDTH-1]}, a rotate left with MSB wrapping to bit 0.
REQ-019 PINGPONG: one-hot bounce with dir register.
- If dir=LEFT and led[WIDTH-1]=1, set dir=RIGHT and shift right.
- If dir=RIGHT and led[0]=1, set dir=LEFT and shift left.
- Otherwise shift in dir.
- Each end bit is lit for exactly one tick per pass.
REQ-020 COUNT: led <= led + 1 modulo 2^WIDTH; all ones wraps to all zeros.
REQ-021 SHALL, if led is not one-hot on a PINGPONG step (not reachable in normal use), load 1 and set dir=LEFT.
REQ-022 SHALL hold led and dir and keep tick=0 while en=0 with no mode change.
REQ-023 SHALL keep tick low in every cycle without a tick-driven led update; tick is never high two consecutive cycles unless DIV_W-speed == 0, which is not permitted by REQ-002.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, set cnt=0, tick=0, dir=LEFT, mode_q<=mode, and led<=init(mode); rst overrides en, step and mode change.
REQ-025 SHALL abandon any in-progress pattern when rst asserts mid-operation; first step after release occurs 2^(DIV_W-speed) cycles after the release edge.

Verification (WIDTH=8, DIV_W=4 unless stated)
REQ-026 Reset mode=0, en=1, speed=0 -> led=0x00 after reset; tick every 16 cycles; led alternates 0xFF, 0x00, 0xFF.
REQ-027 mode=1, speed=2 -> led steps 0x01, 0x02 ... 0x80, 0x01, one step per 4 cycles; tick=1 on each update cycle only.
REQ-028 mode=2, speed=1 -> sequence 0x01, 0x02 ... 0x80, 0x40 ... 0x01, 0x02, one step per 8 cycles; 0x80 and 0x01 each held one period.
REQ-029 mode=3, WIDTH=4 -> led 0x0, 0x1 ... 0xF, 0x0 wraps; en=0 for 40 cycles -> led, cnt and tick frozen, then resume with the same phase.
REQ-030 Switch mode 3 to 1 in the same cycle a step fires -> next cycle led=0x01, tick=0; next tick 16 cycles later at speed 0.
REQ-031 Assert rst mid-PINGPONG with dir=RIGHT and led=0x10 -> led=init(mode), dir=LEFT, tick=0 next cycle; first post-reset step lands exactly at the period boundary.
